core_multicycle_sequencer: RTL and testbench
============================================

// Module: core_multicycle_sequencer
// PURPOSE
//   Multi-cycle control sequencer for the core. It owns the PC and the latched instruction, and drives fetch/LSU handshakes.
//   It sequences FETCH -> EXEC -> (MEM) -> COMMIT and gates GPR/CSR/ecall write enables to a single commit cycle.
//   Adds bus-error and timeout halting, ebreak halt, and cycle/instret performance counters.
// PARAMETERS
//   XLEN        32           PC / address width
//   RESET_PC    32'h80000000 PC value after reset
//   TIMEOUT     255          max cycles spent in a WAIT state before a timeout halt (>=1)
//   PERF_W      32           width of perf_cycles / perf_instret
// PORTS
//   clk           in  1      clock
//   rst           in  1      synchronous reset, active-low (0 = reset)
//   ifu_req_valid out 1      fetch request; ifu_req_addr = pc
//   ifu_req_ready in  1      fetch accepted when valid&ready
//   ifu_req_addr  out XLEN   fetch address
//   ifu_rsp_valid in  1      fetch data valid
//   ifu_rsp_inst  in  32     fetched instruction
//   ifu_rsp_err   in  1      fetch bus error, qualified by ifu_rsp_valid
//   exu_dnpc      in  XLEN   next PC from decode/execute (combinational on inst)
//   exu_is_mem    in  1      instruction is a load/store
//   exu_regwrite  in  1      instruction writes a GPR
//   exu_csr_en    in  1      instruction writes a CSR
//   exu_is_ecall  in  1      instruction is ecall
//   exu_is_ebreak in  1      instruction is ebreak
//   lsu_req_valid out 1      LSU request; accepted when valid&ready
//   lsu_req_ready in  1      LSU accept
//   lsu_rsp_valid in  1      LSU done (load data valid / store complete)
//   lsu_rsp_err   in  1      LSU bus error, qualified by lsu_rsp_valid
//   pc            out XLEN   current PC
//   inst          out 32     latched instruction
//   gpr_wen       out 1      GPR write enable (COMMIT only)
//   csr_wen       out 1      CSR write enable (COMMIT only)
//   ecall_en      out 1      ecall trap enable (COMMIT only)
//   commit        out 1      one-cycle pulse per retired instruction
//   halt          out 1      core halted
//   halt_cause    out 2      0 none, 1 ebreak, 2 bus error, 3 timeout
//   perf_cycles   out PERF_W cycles since reset, excluding HALT
//   perf_instret  out PERF_W retired instructions
// BEHAVIOUR
//   Reset (rst==0 at posedge): state=FETCH_REQ, pc=RESET_PC, inst=0, halt=0, halt_cause=0, counters=0, wait counter=0.
//   - All handshake and enable outputs are 0 during the reset cycle. Reset mid-transaction abandons it without commit.
//   States:
//   - FETCH_REQ: ifu_req_valid=1. On ifu_req_ready go to FETCH_WAIT.
//   - FETCH_WAIT: on ifu_rsp_valid, if err go to HALT(2); else inst<=ifu_rsp_inst and go to EXEC.
//   - EXEC: one settle cycle. If exu_is_mem go to MEM_REQ, else go to COMMIT.
//   - MEM_REQ: lsu_req_valid=1. On lsu_req_ready go to MEM_WAIT.
//   - MEM_WAIT: on lsu_rsp_valid, if err go to HALT(2); else go to COMMIT.
//   - COMMIT: commit=1, gpr_wen=exu_regwrite, csr_wen=exu_csr_en, ecall_en=exu_is_ecall.
//     pc<=exu_dnpc and perf_instret++.
//     If exu_is_ebreak, go to HALT(1) with the ebreak retired; else go to FETCH_REQ.
//   - HALT: terminal until reset. Every output enable and request is 0; pc, inst and counters are frozen.
//   Latency: non-mem instruction takes 4 cycles with ready=1 and rsp in the cycle after accept. Mem instruction takes 6 cycles.
//   Request valid is Moore: it stays high until accepted, with no combinational path from ready to valid.
//   rsp_valid is ignored outside the matching WAIT state. Response in the same cycle as accept is not possible: it is ignored.
//   Wait counter:
//   - Cleared on entry to FETCH_WAIT / MEM_WAIT, incremented each WAIT cycle with no rsp.
//   - Reaching TIMEOUT goes to HALT(3). A rsp in that same cycle wins; no timeout.
//   - Request states never time out.
//   Counters: perf_cycles increments every non-reset cycle while not in HALT. Both counters wrap modulo 2^PERF_W.
//   pc arithmetic: taken verbatim from exu_dnpc; no alignment check here.
// TESTING
//   - ready=1, 1-cycle fetch rsp, addi (regwrite=1) -> gpr_wen pulse at cycle 4, pc 0x80000000->0x80000004, instret=1.
//   - Load with lsu_req_ready held 0 for 3 cycles -> lsu_req_valid stays 1 for 4 cycles, single commit, cycles=9.
//   - ifu_rsp_valid=1 with err=1 -> halt=1, cause=2, no commit, pc unchanged, perf_cycles frozen.
//   - TIMEOUT=4, no fetch rsp -> HALT cause 3 after 4 FETCH_WAIT cycles. Same test with rsp on 4th cycle -> no halt.
//   - ebreak -> commit=1 and instret++, then halt=1, cause=1. Reset (rst=0) mid-MEM_WAIT -> pc=RESET_PC, no commit.
//   - PERF_W=4, run 16 commits -> perf_instret wraps to 0.

Source files
------------

// File: rtl/core_multicycle_sequencer.sv
// Multi-cycle control sequencer: owns PC and instruction register, runs FETCH -> EXEC -> (MEM) -> COMMIT.
// Latency: 4 cycles per non-memory instruction, 6 per memory instruction with ready=1 and next-cycle responses.
// Backpressure: request valids are Moore and held until ready; WAIT states halt on bus error or timeout.
module core_multicycle_sequencer #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h80000000,
  parameter int               TIMEOUT  = 255,
  parameter int               PERF_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_ifu_req_valid,
  input  logic              i_ifu_req_ready,
  output logic [XLEN-1:0]   o_ifu_req_addr,
  input  logic              i_ifu_rsp_valid,
  input  logic [31:0]       i_ifu_rsp_inst,
  input  logic              i_ifu_rsp_err,
  input  logic [XLEN-1:0]   i_exu_dnpc,
  input  logic              i_exu_is_mem,
  input  logic              i_exu_regwrite,
  input  logic              i_exu_csr_en,
  input  logic              i_exu_is_ecall,
  input  logic              i_exu_is_ebreak,
  output logic              o_lsu_req_valid,
  input  logic              i_lsu_req_ready,
  input  logic              i_lsu_rsp_valid,
  input  logic              i_lsu_rsp_err,
  output logic [XLEN-1:0]   o_pc,
  output logic [31:0]       o_inst,
  output logic              o_gpr_wen,
  output logic              o_csr_wen,
  output logic              o_ecall_en,
  output logic              o_commit,
  output logic              o_halt,
  output logic [1:0]        o_halt_cause,
  output logic [PERF_W-1:0] o_perf_cycles,
  output logic [PERF_W-1:0] o_perf_instret
);

  // Wide enough to hold TIMEOUT-1, the last value seen before a timeout fires.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
  localparam logic [1:0] CAUSE_BUSERR  = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH_REQ,
    S_FETCH_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [XLEN-1:0]     r_pc;
  logic [31:0]         r_inst;
  logic [1:0]          r_halt_cause;
  logic [1:0]          w_halt_cause_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic                w_wait_clr;
  logic                w_wait_inc;
  logic                w_inst_ld;
  logic                w_commit;
  logic [PERF_W-1:0]   r_perf_cycles;
  logic [PERF_W-1:0]   r_perf_instret;

  // Next-state decode; WAIT states resolve response before timeout so a last-cycle response wins.
  always_comb begin
    w_state_nxt      = r_state;
    w_halt_cause_nxt = r_halt_cause;
    w_wait_clr       = 1'b0;
    w_wait_inc       = 1'b0;
    w_inst_ld        = 1'b0;
    w_commit         = 1'b0;
    case (r_state)
      S_FETCH_REQ: begin
        if (i_ifu_req_ready) begin
          w_state_nxt = S_FETCH_WAIT;
          w_wait_clr  = 1'b1;
        end
      end
      S_FETCH_WAIT: begin
        if (i_ifu_rsp_valid) begin
          if (i_ifu_rsp_err) begin
            w_state_nxt      = S_HALT;
            w_halt_cause_nxt = CAUSE_BUSERR;
          end else begin
            w_state_nxt = S_EXEC;
            w_inst_ld   = 1'b1;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt      = S_HALT;
          w_halt_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_EXEC: begin
        w_state_nxt = i_exu_is_mem ? S_MEM_REQ : S_COMMIT;
      end
      S_MEM_REQ: begin
        if (i_lsu_req_ready) begin
          w_state_nxt = S_MEM_WAIT;
          w_wait_clr  = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (i_lsu_rsp_valid) begin
          if (i_lsu_rsp_err) begin
            w_state_nxt      = S_HALT;
            w_halt_cause_nxt = CAUSE_BUSERR;
          end else begin
            w_state_nxt = S_COMMIT;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt      = S_HALT;
          w_halt_cause_nxt = CAUSE_TIMEOUT;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      S_COMMIT: begin
        w_commit = 1'b1;
        if (i_exu_is_ebreak) begin
          w_state_nxt      = S_HALT;
          w_halt_cause_nxt = CAUSE_EBREAK;
        end else begin
          w_state_nxt = S_FETCH_REQ;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_FETCH_REQ;
      end
    endcase
  end

  // State and halt-cause register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_FETCH_REQ;
      r_halt_cause <= CAUSE_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_halt_cause <= w_halt_cause_nxt;
    end
  end

  // PC and instruction register; PC only moves at commit, taken verbatim from execute.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_pc   <= RESET_PC;
      r_inst <= '0;
    end else begin
      if (w_commit)  r_pc   <= i_exu_dnpc;
      if (w_inst_ld) r_inst <= i_ifu_rsp_inst;
    end
  end

  // Per-transaction wait counter, restarted each time a request is accepted.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wait <= '0;
    end else if (w_wait_clr) begin
      r_wait <= '0;
    end else if (w_wait_inc) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Performance counters; both wrap naturally and freeze once halted.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_perf_cycles  <= '0;
      r_perf_instret <= '0;
    end else begin
      if (r_state != S_HALT) r_perf_cycles  <= r_perf_cycles + 1'b1;
      if (w_commit)          r_perf_instret <= r_perf_instret + 1'b1;
    end
  end

  // Handshakes and enables are state-decoded and forced low while reset is asserted.
  always_comb begin
    o_ifu_req_valid = i_rst && (r_state == S_FETCH_REQ);
    o_lsu_req_valid = i_rst && (r_state == S_MEM_REQ);
    o_commit        = i_rst && w_commit;
    o_gpr_wen       = o_commit && i_exu_regwrite;
    o_csr_wen       = o_commit && i_exu_csr_en;
    o_ecall_en      = o_commit && i_exu_is_ecall;
  end

  assign o_ifu_req_addr = r_pc;
  assign o_pc           = r_pc;
  assign o_inst         = r_inst;
  assign o_halt         = (r_state == S_HALT);
  assign o_halt_cause   = r_halt_cause;
  assign o_perf_cycles  = r_perf_cycles;
  assign o_perf_instret = r_perf_instret;

endmodule

// File: tb/tb_core_multicycle_sequencer.sv
module tb_core_multicycle_sequencer;
  localparam int          XLEN = 32;
  localparam int          PW   = 4;
  localparam int          TO   = 4;
  localparam logic [31:0] RPC  = 32'h80000000;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            o_ifu_req_valid, i_ifu_req_ready = 1'b0;
  logic [XLEN-1:0] o_ifu_req_addr;
  logic            i_ifu_rsp_valid = 1'b0, i_ifu_rsp_err = 1'b0;
  logic [31:0]     i_ifu_rsp_inst = '0;
  logic [XLEN-1:0] i_exu_dnpc = '0;
  logic            i_exu_is_mem = 1'b0, i_exu_regwrite = 1'b0, i_exu_csr_en = 1'b0;
  logic            i_exu_is_ecall = 1'b0, i_exu_is_ebreak = 1'b0;
  logic            o_lsu_req_valid, i_lsu_req_ready = 1'b0;
  logic            i_lsu_rsp_valid = 1'b0, i_lsu_rsp_err = 1'b0;
  logic [XLEN-1:0] o_pc;
  logic [31:0]     o_inst;
  logic            o_gpr_wen, o_csr_wen, o_ecall_en, o_commit, o_halt;
  logic [1:0]      o_halt_cause;
  logic [PW-1:0]   o_perf_cycles, o_perf_instret;

  core_multicycle_sequencer #(.XLEN(XLEN), .RESET_PC(RPC), .TIMEOUT(TO), .PERF_W(PW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_ifu_req_valid(o_ifu_req_valid), .i_ifu_req_ready(i_ifu_req_ready), .o_ifu_req_addr(o_ifu_req_addr),
    .i_ifu_rsp_valid(i_ifu_rsp_valid), .i_ifu_rsp_inst(i_ifu_rsp_inst), .i_ifu_rsp_err(i_ifu_rsp_err),
    .i_exu_dnpc(i_exu_dnpc), .i_exu_is_mem(i_exu_is_mem), .i_exu_regwrite(i_exu_regwrite),
    .i_exu_csr_en(i_exu_csr_en), .i_exu_is_ecall(i_exu_is_ecall), .i_exu_is_ebreak(i_exu_is_ebreak),
    .o_lsu_req_valid(o_lsu_req_valid), .i_lsu_req_ready(i_lsu_req_ready),
    .i_lsu_rsp_valid(i_lsu_rsp_valid), .i_lsu_rsp_err(i_lsu_rsp_err),
    .o_pc(o_pc), .o_inst(o_inst), .o_gpr_wen(o_gpr_wen), .o_csr_wen(o_csr_wen),
    .o_ecall_en(o_ecall_en), .o_commit(o_commit), .o_halt(o_halt), .o_halt_cause(o_halt_cause),
    .o_perf_cycles(o_perf_cycles), .o_perf_instret(o_perf_instret)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural PC, retired count and elapsed non-halt cycles.
  logic [31:0] m_pc;
  int          m_instret;
  int          m_cycles;

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Random traffic on response lines that the DUT must ignore in the current state.
  task automatic junk_rsp(input bit ifu, input bit lsu);
    if (ifu) begin
      i_ifu_rsp_valid = 1'($urandom);
      i_ifu_rsp_err   = 1'($urandom);
      i_ifu_rsp_inst  = $urandom;
    end
    if (lsu) begin
      i_lsu_rsp_valid = 1'($urandom);
      i_lsu_rsp_err   = 1'($urandom);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_ifu_req_ready = 1'b1; i_lsu_req_ready = 1'b1;
    i_exu_regwrite = 1'b1; i_exu_csr_en = 1'b1; i_exu_is_ecall = 1'b1;
    @(negedge i_clk); #1;
    checks++;
    if ({o_ifu_req_valid, o_lsu_req_valid, o_commit, o_gpr_wen, o_csr_wen, o_ecall_en} !== 6'b0)
      $display("FAIL reset_outputs_low: got %b want 000000",
               {o_ifu_req_valid, o_lsu_req_valid, o_commit, o_gpr_wen, o_csr_wen, o_ecall_en});
    if ({o_ifu_req_valid, o_lsu_req_valid, o_commit, o_gpr_wen, o_csr_wen, o_ecall_en} !== 6'b0) failures++;
    tick();
    i_ifu_req_ready = 1'b0; i_lsu_req_ready = 1'b0;
    i_exu_regwrite = 1'b0; i_exu_csr_en = 1'b0; i_exu_is_ecall = 1'b0;
    i_exu_is_mem = 1'b0; i_exu_is_ebreak = 1'b0;
    i_ifu_rsp_valid = 1'b0; i_lsu_rsp_valid = 1'b0; i_ifu_rsp_err = 1'b0; i_lsu_rsp_err = 1'b0;
    tick();
    i_rst = 1'b1;
    #1;
    m_pc = RPC; m_instret = 0; m_cycles = 0;
    checks++;
    if (o_pc !== RPC || o_inst !== 32'h0 || o_halt !== 1'b0 || o_halt_cause !== 2'd0 ||
        o_perf_cycles !== '0 || o_perf_instret !== '0 || o_ifu_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: pc=%h inst=%h halt=%b cause=%0d cyc=%0d ret=%0d reqv=%b want pc=%h rest 0, reqv=1",
               o_pc, o_inst, o_halt, o_halt_cause, o_perf_cycles, o_perf_instret, o_ifu_req_valid, RPC);
    end
  endtask

  // Drives one instruction through the DUT and checks it against the model.
  // rf/rm: cycles of ready=0 before accept; wf/wm: wait cycle (1-based) carrying the response.
  task automatic run_instr(input int rf, input int wf, input bit mem, input int rm, input int wm,
                           input bit rw, input bit csr, input bit ecall, input bit ebrk,
                           input logic [31:0] iw, input logic [31:0] dnpc);
    int exp_len;
    exp_len = (rf + 1) + wf + 1 + (mem ? (rm + 1) + wm : 0) + 1;
    i_exu_dnpc = dnpc; i_exu_is_mem = mem; i_exu_regwrite = rw;
    i_exu_csr_en = csr; i_exu_is_ecall = ecall; i_exu_is_ebreak = ebrk;
    for (int d = 0; d <= rf; d++) begin
      i_ifu_req_ready = (d == rf);
      junk_rsp(1'b1, 1'b1);
      #1;
      checks++;
      if (o_ifu_req_valid !== 1'b1 || o_ifu_req_addr !== m_pc || o_commit !== 1'b0 || o_lsu_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL fetch_req: valid=%b addr=%h commit=%b lsuv=%b want 1 %h 0 0",
                 o_ifu_req_valid, o_ifu_req_addr, o_commit, o_lsu_req_valid, m_pc);
      end
      tick();
    end
    i_ifu_req_ready = 1'b0;
    for (int w = 1; w <= wf; w++) begin
      i_ifu_rsp_valid = (w == wf);
      i_ifu_rsp_err   = 1'b0;
      i_ifu_rsp_inst  = (w == wf) ? iw : $urandom;
      junk_rsp(1'b0, 1'b1);
      #1;
      checks++;
      if (o_ifu_req_valid !== 1'b0 || o_halt !== 1'b0 || o_commit !== 1'b0) begin
        failures++;
        $display("FAIL fetch_wait: reqv=%b halt=%b commit=%b want 0 0 0", o_ifu_req_valid, o_halt, o_commit);
      end
      tick();
    end
    junk_rsp(1'b1, 1'b1);
    #1;
    checks++;
    if (o_inst !== iw || o_commit !== 1'b0 || o_gpr_wen !== 1'b0) begin
      failures++;
      $display("FAIL exec: inst=%h commit=%b gpr=%b want %h 0 0", o_inst, o_commit, o_gpr_wen, iw);
    end
    tick();
    if (mem) begin
      for (int d = 0; d <= rm; d++) begin
        i_lsu_req_ready = (d == rm);
        junk_rsp(1'b1, 1'b1);
        #1;
        checks++;
        if (o_lsu_req_valid !== 1'b1 || o_ifu_req_valid !== 1'b0 || o_commit !== 1'b0) begin
          failures++;
          $display("FAIL mem_req: lsuv=%b ifuv=%b commit=%b want 1 0 0", o_lsu_req_valid, o_ifu_req_valid, o_commit);
        end
        tick();
      end
      i_lsu_req_ready = 1'b0;
      for (int w = 1; w <= wm; w++) begin
        i_lsu_rsp_valid = (w == wm);
        i_lsu_rsp_err   = 1'b0;
        junk_rsp(1'b1, 1'b0);
        #1;
        checks++;
        if (o_lsu_req_valid !== 1'b0 || o_halt !== 1'b0 || o_commit !== 1'b0) begin
          failures++;
          $display("FAIL mem_wait: lsuv=%b halt=%b commit=%b want 0 0 0", o_lsu_req_valid, o_halt, o_commit);
        end
        tick();
      end
    end
    junk_rsp(1'b1, 1'b1);
    #1;
    checks++;
    if (o_commit !== 1'b1 || o_gpr_wen !== rw || o_csr_wen !== csr || o_ecall_en !== ecall || o_pc !== m_pc) begin
      failures++;
      $display("FAIL commit: commit=%b gpr=%b csr=%b ecall=%b pc=%h want 1 %b %b %b %h",
               o_commit, o_gpr_wen, o_csr_wen, o_ecall_en, o_pc, rw, csr, ecall, m_pc);
    end
    tick();
    m_pc = dnpc; m_instret++; m_cycles += exp_len;
    checks++;
    if (o_pc !== m_pc || o_perf_instret !== PW'(m_instret) || o_perf_cycles !== PW'(m_cycles) ||
        o_commit !== 1'b0 || o_halt !== ebrk || o_halt_cause !== (ebrk ? 2'd1 : 2'd0)) begin
      failures++;
      $display("FAIL retire: pc=%h ret=%0d cyc=%0d commit=%b halt=%b cause=%0d want %h %0d %0d 0 %b %0d",
               o_pc, o_perf_instret, o_perf_cycles, o_commit, o_halt, o_halt_cause,
               m_pc, PW'(m_instret), PW'(m_cycles), ebrk, ebrk ? 1 : 0);
    end
  endtask

  task automatic test_addi();
    test_reset();
    run_instr(0, 1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h00100093, RPC + 32'd4);
    checks++;
    if (o_pc !== 32'h80000004 || o_perf_instret !== 4'd1 || o_perf_cycles !== 4'd4) begin
      failures++;
      $display("FAIL addi: pc=%h ret=%0d cyc=%0d want 80000004 1 4", o_pc, o_perf_instret, o_perf_cycles);
    end
  endtask

  task automatic test_load_stall();
    test_reset();
    run_instr(0, 1, 1'b1, 3, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000a103, RPC + 32'd4);
    checks++;
    if (o_perf_cycles !== 4'd9 || o_perf_instret !== 4'd1) begin
      failures++;
      $display("FAIL load_stall: cyc=%0d ret=%0d want 9 1", o_perf_cycles, o_perf_instret);
    end
  endtask

  task automatic test_random();
    logic [31:0] dn;
    test_reset();
    for (int i = 0; i < 30; i++) begin
      dn = $urandom_range(0, 1) ? m_pc + 32'd4 : ($urandom & 32'hffff_fffc);
      run_instr($urandom_range(0, 2), $urandom_range(1, TO), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(1, TO), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, $urandom, dn);
    end
  endtask

  task automatic test_instret_wrap();
    test_reset();
    for (int i = 0; i < 16; i++)
      run_instr(0, 1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, $urandom, m_pc + 32'd4);
    checks++;
    if (o_perf_instret !== 4'd0 || o_pc !== RPC + 32'd64) begin
      failures++;
      $display("FAIL instret_wrap: ret=%0d pc=%h want 0 %h", o_perf_instret, o_pc, RPC + 32'd64);
    end
  endtask

  // Leaves the DUT halted; checks it stays frozen and silent.
  task automatic check_halted(input logic [1:0] cause, input logic [31:0] pc, input int cyc, input int ret);
    for (int k = 0; k < 3; k++) begin
      i_ifu_req_ready = 1'b1; i_lsu_req_ready = 1'b1; junk_rsp(1'b1, 1'b1);
      #1;
      checks++;
      if (o_halt !== 1'b1 || o_halt_cause !== cause || o_pc !== pc || o_perf_cycles !== PW'(cyc) ||
          o_perf_instret !== PW'(ret) || o_commit !== 1'b0 || o_ifu_req_valid !== 1'b0 || o_lsu_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL halted: halt=%b cause=%0d pc=%h cyc=%0d ret=%0d commit=%b reqv=%b/%b want 1 %0d %h %0d %0d 0 0/0",
                 o_halt, o_halt_cause, o_pc, o_perf_cycles, o_perf_instret, o_commit, o_ifu_req_valid,
                 o_lsu_req_valid, cause, pc, PW'(cyc), PW'(ret));
      end
      tick();
    end
    i_ifu_req_ready = 1'b0; i_lsu_req_ready = 1'b0;
  endtask

  task automatic test_fetch_err();
    test_reset();
    run_instr(0, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 32'h80000100);
    i_ifu_req_ready = 1'b1; i_ifu_rsp_valid = 1'b0; tick();
    i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b1; i_ifu_rsp_err = 1'b1;
    #1;
    checks++;
    if (o_commit !== 1'b0 || o_halt !== 1'b0) begin
      failures++;
      $display("FAIL fetch_err_cycle: commit=%b halt=%b want 0 0", o_commit, o_halt);
    end
    tick();
    check_halted(2'd2, 32'h80000100, m_cycles + 2, m_instret);
  endtask

  task automatic test_lsu_err();
    test_reset();
    i_exu_is_mem = 1'b1; i_exu_regwrite = 1'b1;
    i_ifu_req_ready = 1'b1; tick();
    i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b1; i_ifu_rsp_err = 1'b0; tick();
    i_ifu_rsp_valid = 1'b0; tick();
    i_lsu_req_ready = 1'b1; tick();
    i_lsu_req_ready = 1'b0; i_lsu_rsp_valid = 1'b1; i_lsu_rsp_err = 1'b1; tick();
    i_lsu_rsp_valid = 1'b0; i_lsu_rsp_err = 1'b0;
    check_halted(2'd2, RPC, 5, 0);
  endtask

  task automatic test_timeout();
    test_reset();
    i_ifu_req_ready = 1'b1; tick();
    i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b0;
    for (int w = 1; w < TO; w++) tick();
    checks++;
    if (o_halt !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: halt=%b want 0 after %0d wait cycles", o_halt, TO - 1);
    end
    tick();
    check_halted(2'd3, RPC, 1 + TO, 0);
  endtask

  task automatic test_ebreak();
    test_reset();
    run_instr(1, 2, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, RPC + 32'd4);
    run_instr(0, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00100073, RPC + 32'd8);
    check_halted(2'd1, RPC + 32'd8, m_cycles, 2);
  endtask

  task automatic test_reset_mid_mem();
    test_reset();
    run_instr(0, 1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, RPC + 32'd4);
    i_exu_is_mem = 1'b1; i_exu_regwrite = 1'b1; i_exu_dnpc = 32'h12345678;
    i_ifu_req_ready = 1'b1; tick();
    i_ifu_req_ready = 1'b0; i_ifu_rsp_valid = 1'b1; i_ifu_rsp_err = 1'b0; tick();
    i_ifu_rsp_valid = 1'b0; tick();
    i_lsu_req_ready = 1'b1; tick();
    i_lsu_req_ready = 1'b0; i_lsu_rsp_valid = 1'b0; tick();
    i_rst = 1'b0; i_lsu_rsp_valid = 1'b1; i_lsu_rsp_err = 1'b0;
    #1;
    checks++;
    if (o_commit !== 1'b0 || o_gpr_wen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_commit: commit=%b gpr=%b want 0 0", o_commit, o_gpr_wen);
    end
    tick();
    i_rst = 1'b1; i_lsu_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (o_pc !== RPC || o_commit !== 1'b0 || o_perf_instret !== 4'd0 || o_ifu_req_valid !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_state: pc=%h commit=%b ret=%0d reqv=%b want %h 0 0 1",
                 o_pc, o_commit, o_perf_instret, o_ifu_req_valid, RPC);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_stall();
    test_random();
    test_instret_wrap();
    test_fetch_err();
    test_lsu_err();
    test_timeout();
    test_ebreak();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
